alu_exec_unit: RTL and testbench

- Parametrised, registered successor to the combinational ALU control unit. It decodes ALUop/funct3/funct7 into an ALU selection and executes the operation.
- Adds an iterative shift-add multiplier (RV32M MUL, low half) and valid/ready handshakes on input and output.
- Sits in the EX stage between the operand latches and the writeback mux. It stalls upstream through in_ready while a multiply is in flight.

---
 rtl/alu_exec_unit_if.sv | 30 +++
 rtl/alu_exec_unit.sv | 198 +++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle for alu_exec_unit: operand/decode request with valid/ready,
// and result with valid/ready back toward writeback.
interface alu_exec_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alu_op;
  logic [2:0]       funct3;
  logic             funct7_b5;
  logic             funct7_b0;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       alu_sel;
  logic             zero;
  logic             illegal;

  modport master (
    output in_valid, alu_op, funct3, funct7_b5, funct7_b0, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, alu_sel, zero, illegal
  );

  modport slave (
    input  in_valid, alu_op, funct3, funct7_b5, funct7_b0, op_a, op_b, out_ready,
    output in_ready, out_valid, result, alu_sel, zero, illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Registered EX-stage ALU: decodes ALUop/funct fields, executes single-cycle ops and an
// iterative shift-add MUL (low half), with valid/ready on both sides.
module alu_exec_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_BPC = 1,
  parameter int unsigned M_EXT   = 1
) (
  input logic            clk,
  input logic            rst_n,
  alu_exec_unit_if.slave bus
);
  localparam int unsigned SHW     = $clog2(WIDTH);
  localparam int unsigned MUL_CYC = WIDTH / MUL_BPC;
  localparam int unsigned CW      = $clog2(MUL_CYC + 1);

  if ((WIDTH < 8) || (WIDTH > 64) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
    $error("alu_exec_unit: WIDTH must be a power of two in 8..64");
  end
  if ((MUL_BPC == 0) || ((WIDTH % MUL_BPC) != 0)) begin : g_bad_bpc
    $error("alu_exec_unit: MUL_BPC must divide WIDTH");
  end

  typedef enum logic [3:0] {
    SEL_ADD  = 4'b0000,
    SEL_SUB  = 4'b0001,
    SEL_SLL  = 4'b0010,
    SEL_SLT  = 4'b0011,
    SEL_SLTU = 4'b0100,
    SEL_XOR  = 4'b0101,
    SEL_SRL  = 4'b0110,
    SEL_SRA  = 4'b0111,
    SEL_OR   = 4'b1000,
    SEL_AND  = 4'b1001,
    SEL_MUL  = 4'b1010,
    SEL_NONE = 4'b1111
  } sel_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_e;

  state_e           state;
  sel_e             dec_sel;
  logic             dec_ill;
  logic [WIDTH-1:0] alu_res;
  logic [SHW-1:0]   shamt;
  logic             in_ready_w;
  logic             accept;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] mul_step;
  logic [CW-1:0]    cnt;

  logic             out_valid_q;
  logic [WIDTH-1:0] res_q;
  sel_e             sel_q;
  logic             zero_q;
  logic             ill_q;

  // Decode
  always_comb begin
    dec_sel = SEL_NONE;
    dec_ill = 1'b0;
    case (bus.alu_op)
      2'b00: dec_sel = SEL_ADD;
      2'b01: dec_sel = SEL_SUB;
      default: begin
        if ((bus.alu_op == 2'b10) && bus.funct7_b0) begin
          if ((bus.funct3 == 3'b000) && (M_EXT != 0)) begin
            dec_sel = SEL_MUL;
          end else begin
            dec_sel = SEL_NONE;
            dec_ill = 1'b1;
          end
        end else begin
          case (bus.funct3)
            3'b000: begin
              // I-type has no SUBI: bit 30 is part of the immediate there
              if ((bus.alu_op == 2'b10) && bus.funct7_b5) dec_sel = SEL_SUB;
              else                                         dec_sel = SEL_ADD;
            end
            3'b001: dec_sel = SEL_SLL;
            3'b010: dec_sel = SEL_SLT;
            3'b011: dec_sel = SEL_SLTU;
            3'b100: dec_sel = SEL_XOR;
            3'b101: begin
              if (bus.funct7_b5) dec_sel = SEL_SRA;
              else               dec_sel = SEL_SRL;
            end
            3'b110: dec_sel = SEL_OR;
            default: dec_sel = SEL_AND;
          endcase
        end
      end
    endcase
  end

  // Single-cycle execute
  always_comb begin
    shamt   = bus.op_b[SHW-1:0];
    alu_res = '0;
    case (dec_sel)
      SEL_ADD:  alu_res = bus.op_a + bus.op_b;
      SEL_SUB:  alu_res = bus.op_a - bus.op_b;
      SEL_SLL:  alu_res = bus.op_a << shamt;
      SEL_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
      SEL_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.op_a < bus.op_b)};
      SEL_XOR:  alu_res = bus.op_a ^ bus.op_b;
      SEL_SRL:  alu_res = bus.op_a >> shamt;
      SEL_SRA:  alu_res = $signed(bus.op_a) >>> shamt;
      SEL_OR:   alu_res = bus.op_a | bus.op_b;
      SEL_AND:  alu_res = bus.op_a & bus.op_b;
      default:  alu_res = '0;
    endcase
  end

  // One multiplier step: MUL_BPC partial products from the low multiplier bits
  always_comb begin
    logic [WIDTH-1:0] bits;
    mul_step = acc;
    for (int unsigned j = 0; j < MUL_BPC; j++) begin
      bits = mplier >> j;
      if (bits[0]) mul_step = mul_step + (mcand << j);
    end
  end

  assign in_ready_w = (state == S_IDLE) || ((state == S_DONE) && bus.out_ready);
  assign accept     = bus.in_valid && in_ready_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      sel_q       <= SEL_ADD;
      zero_q      <= 1'b0;
      ill_q       <= 1'b0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            if (dec_sel == SEL_MUL) begin
              state       <= S_MUL;
              out_valid_q <= 1'b0;
              acc         <= '0;
              mcand       <= bus.op_a;
              mplier      <= bus.op_b;
              cnt         <= CW'(MUL_CYC);
            end else begin
              state       <= S_DONE;
              out_valid_q <= 1'b1;
              res_q       <= alu_res;
              sel_q       <= dec_sel;
              zero_q      <= (alu_res == '0);
              ill_q       <= dec_ill;
            end
          end else if ((state == S_DONE) && bus.out_ready) begin
            state       <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        S_MUL: begin
          acc    <= mul_step;
          mcand  <= mcand << MUL_BPC;
          mplier <= mplier >> MUL_BPC;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state       <= S_DONE;
            out_valid_q <= 1'b1;
            res_q       <= mul_step;
            sel_q       <= SEL_MUL;
            zero_q      <= (mul_step == '0);
            ill_q       <= 1'b0;
          end
        end
        default: begin
          state       <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = res_q;
  assign bus.alu_sel   = sel_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = ill_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: expected results queued at issue,
// popped and compared where each task observes the output.
module tb_alu_exec_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_exec_unit_if #(.WIDTH(32)) bus ();

  alu_exec_unit #(.WIDTH(32), .MUL_BPC(1), .M_EXT(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic [3:0]  sel;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Drives one request and holds in_valid until accepted (bounded); returns at accept edge + 1.
  task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic b5, input logic b0,
                      input logic [31:0] a, input logic [31:0] b, input logic track,
                      input logic [31:0] er, input logic [3:0] es, input logic ei);
    logic ok;
    logic accepted;
    bus.alu_op    = op;
    bus.funct3    = f3;
    bus.funct7_b5 = b5;
    bus.funct7_b0 = b0;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.in_valid  = 1'b1;
    if (track) sb.push_back('{er, es, ei});
    accepted = 1'b0;
    for (int i = 0; i < 100 && !accepted; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      if (ok === 1'b1) accepted = 1'b1;
    end
    #1 bus.in_valid = 1'b0;
    if (!accepted) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: request op=%b f3=%b never accepted", op, f3);
    end
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if ({bus.out_valid, bus.result, bus.alu_sel, bus.zero, bus.illegal} !== 39'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b r=%h s=%b z=%b i=%b, want all 0",
               bus.out_valid, bus.result, bus.alu_sel, bus.zero, bus.illegal);
    end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_legacy_decode();
    logic [1:0]  ops [6] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
    logic [2:0]  f3s [6] = '{3'b011, 3'b000, 3'b000, 3'b000, 3'b111, 3'b110};
    logic        b5s [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0]  sels[6] = '{4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b1001, 4'b1000};
    logic [31:0] ress[6] = '{32'd12, 32'd2, 32'd12, 32'd2, 32'd5, 32'd7};
    exp_t e;
    logic [37:0] act, want;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      send(ops[k], f3s[k], b5s[k], 1'b0, 32'd7, 32'd5, 1'b1, ress[k], sels[k], 1'b0);
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b1) begin
        n_err++; $display("FAIL legacy_latency[%0d]: out_valid=%b want 1", k, bus.out_valid);
      end
      e = sb.pop_front();
      act  = {bus.result, bus.alu_sel, bus.zero, bus.illegal};
      want = {e.res, e.sel, (e.res == 32'd0), e.ill};
      n_cmp++;
      if (act !== want) begin
        n_err++; $display("FAIL legacy_decode[%0d]: got %h want %h", k, act, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_arith();
    logic [2:0]  f3s [6] = '{3'b000, 3'b010, 3'b011, 3'b101, 3'b001, 3'b000};
    logic        b5s [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] as  [6] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                             32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] bs  [6] = '{32'd1, 32'd1, 32'd1, 32'd31, 32'd33, 32'd1};
    logic [3:0]  sels[6] = '{4'b0001, 4'b0011, 4'b0100, 4'b0111, 4'b0010, 4'b0000};
    logic [31:0] ress[6] = '{32'h7FFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0};
    exp_t e;
    logic [37:0] act, want;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      send(2'b10, f3s[k], b5s[k], 1'b0, as[k], bs[k], 1'b1, ress[k], sels[k], 1'b0);
      @(negedge clk);
      e = sb.pop_front();
      act  = {bus.result, bus.alu_sel, bus.zero, bus.illegal};
      want = {e.res, e.sel, (e.res == 32'd0), e.ill};
      n_cmp++;
      if ((bus.out_valid !== 1'b1) || (act !== want)) begin
        n_err++; $display("FAIL arith[%0d]: got v=%b %h want v=1 %h", k, bus.out_valid, act, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mul();
    exp_t e;
    logic [37:0] act, want;
    int lat;
    logic ready_seen;
    bus.out_ready = 1'b1;
    send(2'b10, 3'b000, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd3, 1'b1, 32'hFFFF_FFFD, 4'b1010, 1'b0);
    lat = 0;
    ready_seen = 1'b0;
    // Competing request and operand churn during the multiply must be ignored
    bus.alu_op = 2'b00; bus.op_a = 32'd1; bus.op_b = 32'd1; bus.in_valid = 1'b1;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (k == 20) bus.in_valid = 1'b0;
      bus.op_a = $urandom; bus.op_b = $urandom;
      if (bus.out_valid === 1'b1) lat = k;
      else if (bus.in_ready !== 1'b0) ready_seen = 1'b1;
    end
    bus.in_valid = 1'b0;
    n_cmp++;
    if (ready_seen) begin
      n_err++; $display("FAIL mul_in_ready: in_ready went high during multiply, want 0");
    end
    n_cmp++;
    if (lat != 32) begin
      n_err++; $display("FAIL mul_latency: got %0d edges want 32", lat);
    end
    @(negedge clk);
    e = sb.pop_front();
    act  = {bus.result, bus.alu_sel, bus.zero, bus.illegal};
    want = {e.res, e.sel, (e.res == 32'd0), e.ill};
    n_cmp++;
    if (act !== want) begin
      n_err++; $display("FAIL mul_result: got %h want %h", act, want);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [37:0] act, want;
    bus.out_ready = 1'b0;
    send(2'b00, 3'b000, 1'b0, 1'b0, 32'd1, 32'd2, 1'b1, 32'd3, 4'b0000, 1'b0);
    bus.alu_op = 2'b10; bus.funct3 = 3'b100; bus.funct7_b5 = 1'b0; bus.funct7_b0 = 1'b0;
    bus.op_a = 32'hF0; bus.op_b = 32'hFF; bus.in_valid = 1'b1;
    sb.push_back('{32'h0F, 4'b0101, 1'b0});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.out_valid, bus.result, bus.alu_sel, bus.in_ready} !== {1'b1, 32'd3, 4'b0000, 1'b0}) begin
        n_err++;
        $display("FAIL backpressure_hold[%0d]: got v=%b r=%h s=%b rdy=%b want v=1 r=3 s=0000 rdy=0",
                 k, bus.out_valid, bus.result, bus.alu_sel, bus.in_ready);
      end
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL b2b_in_ready: got %b want 1", bus.in_ready);
    end
    e = sb.pop_front();
    act  = {bus.result, bus.alu_sel, bus.zero, bus.illegal};
    want = {e.res, e.sel, (e.res == 32'd0), e.ill};
    n_cmp++;
    if (act !== want) begin
      n_err++; $display("FAIL b2b_first: got %h want %h", act, want);
    end
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    act  = {bus.result, bus.alu_sel, bus.zero, bus.illegal};
    want = {e.res, e.sel, (e.res == 32'd0), e.ill};
    n_cmp++;
    if ((bus.out_valid !== 1'b1) || (act !== want)) begin
      n_err++; $display("FAIL b2b_second: got v=%b %h want v=1 %h", bus.out_valid, act, want);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    exp_t e;
    logic [37:0] act, want;
    bus.out_ready = 1'b1;
    send(2'b10, 3'b100, 1'b0, 1'b1, 32'd5, 32'd6, 1'b1, 32'd0, 4'b1111, 1'b1);
    @(negedge clk);
    e = sb.pop_front();
    act  = {bus.result, bus.alu_sel, bus.zero, bus.illegal};
    want = {e.res, e.sel, (e.res == 32'd0), e.ill};
    n_cmp++;
    if ((bus.out_valid !== 1'b1) || (act !== want)) begin
      n_err++; $display("FAIL illegal_decode: got v=%b %h want v=1 %h", bus.out_valid, act, want);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_mul();
    exp_t e;
    logic [37:0] act, want;
    logic seen;
    bus.out_ready = 1'b1;
    send(2'b10, 3'b000, 1'b0, 1'b1, 32'd5, 32'd7, 1'b0, 32'd0, 4'b0000, 1'b0);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.result, bus.alu_sel} !== 37'd0) begin
      n_err++; $display("FAIL midreset_outputs: got v=%b r=%h s=%b want 0", bus.out_valid, bus.result, bus.alu_sel);
    end
    #2 rst_n = 1'b1;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL midreset_in_ready: got %b want 1", bus.in_ready);
    end
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_err++; $display("FAIL midreset_discard: out_valid rose after reset, want 0");
    end
    @(posedge clk); #1;
    send(2'b00, 3'b000, 1'b0, 1'b0, 32'd2, 32'd3, 1'b1, 32'd5, 4'b0000, 1'b0);
    @(negedge clk);
    e = sb.pop_front();
    act  = {bus.result, bus.alu_sel, bus.zero, bus.illegal};
    want = {e.res, e.sel, (e.res == 32'd0), e.ill};
    n_cmp++;
    if ((bus.out_valid !== 1'b1) || (act !== want)) begin
      n_err++; $display("FAIL post_reset_add: got v=%b %h want v=1 %h", bus.out_valid, act, want);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.alu_op    = 2'b00;
    bus.funct3    = 3'b000;
    bus.funct7_b5 = 1'b0;
    bus.funct7_b0 = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_legacy_decode();
    test_arith();
    test_mul();
    test_back_to_back();
    test_illegal();
    test_reset_mid_mul();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
